// File: rtl/escritor_pkg.sv
// Shared types and widths for the register-bank write buffer.
// Optional forwarding lookup is enabled with WB_FWD_EN.
package escritor_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } entry_t;

endpackage

// File: rtl/escritor_banco_fifo_wb.sv
// Pending-write storage: circular buffer with read/write pointers.
// Entry array and read pointer are exported only under WB_FWD_EN.
module fifo_wb
  import escritor_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  entry_t                   wr_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
`ifdef WB_FWD_EN
  output entry_t [DEPTH-1:0]       mem_o,
  output logic   [PW-1:0]          rd_ptr_o,
`endif
  output logic   [CW-1:0]          count_o
);

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic   [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic   [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic   [CW-1:0]    cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  // Guards keep occupancy in 0..DEPTH even if a caller misbehaves.
  assign push_ok = push_i && (cnt_q < CW'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;

`ifdef WB_FWD_EN
  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;
`endif

endmodule

// File: rtl/escritor_banco.sv
// Write-back buffer in front of the register bank: handshake, x0 filter.
// Define WB_FWD_EN to add the youngest-match forwarding lookup.
module escritor_banco
  import escritor_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0]     in_data,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0]     Writedata,
  output logic                  Regwrite,
  input  logic                  bank_ready,
`ifdef WB_FWD_EN
  input  logic [REG_ADDR_W-1:0] fwd_reg,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data,
`endif
  output logic [CW-1:0]         count
);

  entry_t head;
  entry_t wr_ent;
  logic   push, pop;

  assign in_ready = !rst && (count < CW'(DEPTH));
  // Writes to x0 are accepted but never reach the bank.
  assign push     = in_valid && in_ready && (in_reg != '0);
  assign pop      = Regwrite && bank_ready;
  assign wr_ent   = '{rd: in_reg, data: in_data};

`ifdef WB_FWD_EN
  entry_t [DEPTH-1:0] mem;
  logic   [PW-1:0]    rd_ptr;
  logic   [PW-1:0]    fwd_idx;
`endif

  fifo_wb #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .wr_i     (wr_ent),
    .pop_i    (pop),
    .head_o   (head),
`ifdef WB_FWD_EN
    .mem_o    (mem),
    .rd_ptr_o (rd_ptr),
`endif
    .count_o  (count)
  );

  assign Regwrite  = (count != '0);
  assign WriteReg  = head.rd;
  assign Writedata = head.data;

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (fwd_reg != '0) &&
          (mem[fwd_idx].rd == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[fwd_idx].data;
      end
    end
  end
`endif

endmodule
